// File: rtl/bram32_arb_pkg.sv
// Shared types and constants for the two-port 32-bit block RAM arbiter.
package bram32_arb_pkg;

    localparam int NUM_PORTS = 2;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2,
        SZ_ILL  = 2'd3
    } size_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RESP = 2'd1,
        ST_HOLD = 2'd2
    } state_e;

    // RAM write-subaddress codes; half and byte codes are bases plus lane offset
    localparam logic [2:0] SUB_WORD  = 3'd1;
    localparam logic [2:0] SUB_HALF0 = 3'd2;
    localparam logic [2:0] SUB_BYTE0 = 3'd4;

endpackage

// File: rtl/bram32_lane_align.sv
// Lane helper: maps request size/offset to the RAM write subaddress and alignment
// error, and extracts right-justified, zero-extended read data for a response.
module bram32_lane_align
    import bram32_arb_pkg::*;
(
    input  size_e       req_size,
    input  logic [1:0]  req_off,
    input  size_e       rsp_size,
    input  logic [1:0]  rsp_off,
    input  logic [31:0] mem_rdata,
    output logic [2:0]  wr_subaddr,
    output logic        req_err,
    output logic [31:0] rsp_data
);

    // Request side: subaddress code and misalignment / illegal-size flag
    always_comb begin
        wr_subaddr = 3'd0;
        req_err    = 1'b0;
        case (req_size)
            SZ_BYTE: begin
                wr_subaddr = SUB_BYTE0 | {1'b0, req_off};
                req_err    = 1'b0;
            end
            SZ_HALF: begin
                wr_subaddr = SUB_HALF0 | {2'b00, req_off[1]};
                req_err    = req_off[0];
            end
            SZ_WORD: begin
                wr_subaddr = SUB_WORD;
                req_err    = (req_off != 2'b00);
            end
            default: begin
                wr_subaddr = 3'd0;
                req_err    = 1'b1;
            end
        endcase
    end

    // Response side: select the addressed lane and right-justify it
    always_comb begin
        rsp_data = 32'd0;
        case (rsp_size)
            SZ_BYTE: rsp_data = {24'd0, mem_rdata[{rsp_off, 3'b000} +: 8]};
            SZ_HALF: rsp_data = {16'd0, mem_rdata[{rsp_off[1], 4'b0000} +: 16]};
            SZ_WORD: rsp_data = mem_rdata;
            default: rsp_data = 32'd0;
        endcase
    end

endmodule

// File: rtl/bram32_arbiter.sv
// Two-port valid/ready arbiter in front of one 32-bit byte-addressable block RAM.
// Define BRAM_ARB_FIXED_PRIO_EN for fixed port-0 priority instead of round-robin.
module bram32_arbiter
    import bram32_arb_pkg::*;
#(
    parameter  int DEPTH      = 512,
    localparam int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                                  i_clk,
    input  logic                                  i_rst_n,
    input  logic [NUM_PORTS-1:0]                  i_req_valid,
    output logic [NUM_PORTS-1:0]                  o_req_ready,
    input  logic [NUM_PORTS-1:0][ADDR_WIDTH+1:0]  i_req_addr,
    input  logic [NUM_PORTS-1:0]                  i_req_we,
    input  logic [NUM_PORTS-1:0][1:0]             i_req_size,
    input  logic [NUM_PORTS-1:0][31:0]            i_req_wdata,
    output logic [NUM_PORTS-1:0]                  o_rsp_valid,
    input  logic [NUM_PORTS-1:0]                  i_rsp_ready,
    output logic [31:0]                           o_rsp_rdata,
    output logic                                  o_rsp_err,
    output logic [ADDR_WIDTH-1:0]                 o_mem_addr,
    output logic [31:0]                           o_mem_wdata,
    output logic                                  o_mem_we,
    output logic [2:0]                            o_mem_wr_subaddr,
    input  logic [31:0]                           i_mem_rdata
);

    state_e               st_r;
    logic                 owner_r;
    logic [1:0]           off_r;
    size_e                size_r;
    logic                 we_r;
    logic                 err_r;
    logic [31:0]          hold_r;
`ifndef BRAM_ARB_FIXED_PRIO_EN
    logic                 rr_r;
`endif

    logic                 win_s;
    logic                 gnt_port_s;
    logic                 gnt_any_s;
    logic [ADDR_WIDTH+1:0] sel_addr_s;
    logic [1:0]           sel_size_s;
    logic                 sel_we_s;
    logic [31:0]          sel_wdata_s;
    logic [2:0]           req_sub_s;
    logic                 req_err_s;
    logic [31:0]          aligned_s;
    logic [31:0]          live_data_s;

    bram32_lane_align u_lane_align (
        .req_size   (size_e'(sel_size_s)),
        .req_off    (sel_addr_s[1:0]),
        .rsp_size   (size_r),
        .rsp_off    (off_r),
        .mem_rdata  (i_mem_rdata),
        .wr_subaddr (req_sub_s),
        .req_err    (req_err_s),
        .rsp_data   (aligned_s)
    );

    // Arbitration: choose which valid requester would be served this cycle
    always_comb begin
        gnt_port_s = 1'b0;
`ifdef BRAM_ARB_FIXED_PRIO_EN
        if (i_req_valid[0]) begin
            gnt_port_s = 1'b0;
        end else begin
            gnt_port_s = 1'b1;
        end
`else
        case (i_req_valid)
            2'b01:   gnt_port_s = 1'b0;
            2'b10:   gnt_port_s = 1'b1;
            2'b11:   gnt_port_s = ~rr_r;
            default: gnt_port_s = 1'b0;
        endcase
`endif
    end

    // Grant window opens when idle or when the pending response is taken this cycle
    always_comb begin
        if (st_r == ST_IDLE) begin
            win_s = 1'b1;
        end else begin
            win_s = i_rsp_ready[owner_r];
        end
        gnt_any_s   = i_rst_n & win_s & (|i_req_valid);
        sel_addr_s  = i_req_addr[gnt_port_s];
        sel_size_s  = i_req_size[gnt_port_s];
        sel_we_s    = i_req_we[gnt_port_s];
        sel_wdata_s = i_req_wdata[gnt_port_s];
    end

    // Request-side outputs: handshake and RAM command for the granted request
    always_comb begin
        o_req_ready      = 2'b00;
        o_mem_addr       = {ADDR_WIDTH{1'b0}};
        o_mem_wdata      = 32'd0;
        o_mem_we         = 1'b0;
        o_mem_wr_subaddr = 3'd0;
        if (gnt_any_s) begin
            o_req_ready = gnt_port_s ? 2'b10 : 2'b01;
            if (!req_err_s) begin
                o_mem_addr  = sel_addr_s[ADDR_WIDTH+1:2];
                o_mem_wdata = sel_wdata_s;
                o_mem_we    = sel_we_s;
                if (sel_we_s) begin
                    o_mem_wr_subaddr = req_sub_s;
                end else begin
                    o_mem_wr_subaddr = 3'd0;
                end
            end else begin
                o_mem_we = 1'b0;
            end
        end else begin
            o_req_ready = 2'b00;
        end
    end

    // Response path: live RAM lane in RESP, captured copy in HOLD
    always_comb begin
        live_data_s = (we_r || err_r) ? 32'd0 : aligned_s;
        o_rsp_valid = 2'b00;
        o_rsp_rdata = 32'd0;
        o_rsp_err   = 1'b0;
        if (i_rst_n && (st_r != ST_IDLE)) begin
            o_rsp_valid = owner_r ? 2'b10 : 2'b01;
            o_rsp_err   = err_r;
            case (st_r)
                ST_RESP: o_rsp_rdata = live_data_s;
                ST_HOLD: o_rsp_rdata = hold_r;
                default: o_rsp_rdata = 32'd0;
            endcase
        end else begin
            o_rsp_valid = 2'b00;
        end
    end

    // Arbiter FSM: latch the granted request, then hold its response until taken
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            st_r    <= ST_IDLE;
            owner_r <= 1'b0;
            off_r   <= 2'b00;
            size_r  <= SZ_BYTE;
            we_r    <= 1'b0;
            err_r   <= 1'b0;
            hold_r  <= 32'd0;
`ifndef BRAM_ARB_FIXED_PRIO_EN
            rr_r    <= 1'b1;
`endif
        end else begin
            if (gnt_any_s) begin
                st_r    <= ST_RESP;
                owner_r <= gnt_port_s;
                off_r   <= sel_addr_s[1:0];
                size_r  <= size_e'(sel_size_s);
                we_r    <= sel_we_s;
                err_r   <= req_err_s;
`ifndef BRAM_ARB_FIXED_PRIO_EN
                rr_r    <= gnt_port_s;
`endif
            end else if ((st_r == ST_RESP) && !i_rsp_ready[owner_r]) begin
                // RAM output is only valid this one cycle, so keep a copy
                st_r   <= ST_HOLD;
                hold_r <= live_data_s;
            end else if ((st_r != ST_IDLE) && i_rsp_ready[owner_r]) begin
                st_r <= ST_IDLE;
            end else begin
                st_r <= st_r;
            end
        end
    end

endmodule
